// File: rtl/ahb_master_mux_pkg.sv
// Shared types and constants for the AHB master multiplexer slice.
// Optional feature macro: AHB_MASTER_MUX_STATS_EN (transfer counter).
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef logic [2:0] hburst_t;
  typedef logic [2:0] hsize_t;

  typedef enum logic {
    DP_IDLE = 1'b0,
    DP_BUSY = 1'b1
  } dp_state_t;

  localparam int MASTER_IDX_W = 4;

  // Only NONSEQ and SEQ move data; IDLE and BUSY leave the data phase empty.
  function automatic logic is_active_trans(logic [1:0] trans);
    return (trans == NONSEQ) || (trans == SEQ);
  endfunction

endpackage

// File: rtl/ahb_master_mux_if.sv
// Bus bundle for ahb_master_mux: per-master request fields in, shared bus out.
// Optional feature macro: AHB_MASTER_MUX_STATS_EN (counter is a plain port, not here).
interface ahb_master_mux_if
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);

  logic [MASTER_IDX_W-1:0]       HMASTER;
  logic                          HREADY;
  logic [NUM_MASTERS*ADDR_W-1:0] HADDRx;
  logic [NUM_MASTERS*2-1:0]      HTRANSx;
  logic [NUM_MASTERS-1:0]        HWRITEx;
  logic [NUM_MASTERS*3-1:0]      HSIZEx;
  logic [NUM_MASTERS*3-1:0]      HBURSTx;
  logic [NUM_MASTERS*DATA_W-1:0] HWDATAx;

  logic [ADDR_W-1:0]             HADDR;
  logic [1:0]                    HTRANS;
  logic                          HWRITE;
  hsize_t                        HSIZE;
  hburst_t                       HBURST;
  logic [DATA_W-1:0]             HWDATA;
  logic [MASTER_IDX_W-1:0]       HMASTER_DP;
  logic                          DP_ACTIVE;
  logic                          PROTO_ERR;

  // The mux itself: consumes master requests, drives the shared bus.
  modport master (
    input  HMASTER, HREADY, HADDRx, HTRANSx, HWRITEx, HSIZEx, HBURSTx, HWDATAx,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HMASTER_DP, DP_ACTIVE, PROTO_ERR
  );

  // The surrounding system: supplies requests, observes the shared bus.
  modport slave (
    output HMASTER, HREADY, HADDRx, HTRANSx, HWRITEx, HSIZEx, HBURSTx, HWDATAx,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HMASTER_DP, DP_ACTIVE, PROTO_ERR
  );

endinterface

// File: rtl/ahb_master_mux_dp_tracker.sv
// Data-phase ownership tracker: registers the data-phase master, runs the
// handover FSM and flags a master change while a data phase is wait-stated.
// Optional feature macro: AHB_MASTER_MUX_STATS_EN (completed-transfer counter).
module ahb_master_dp_tracker
  import ahb_pkg::*;
(
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [MASTER_IDX_W-1:0] HMASTER,
  input  logic                    HREADY,
  input  logic                    sel_active,
  input  logic                    sel_write,
`ifdef AHB_MASTER_MUX_STATS_EN
  output logic [31:0]             STAT_XFER_CNT,
`endif
  output logic [MASTER_IDX_W-1:0] HMASTER_DP,
  output logic                    DP_ACTIVE,
  output logic                    WRITE_DP,
  output logic                    PROTO_ERR
);

  dp_state_t               state;
  dp_state_t               state_next;
  logic [MASTER_IDX_W-1:0] hmaster_prev;
  logic                    handover_err;

  // Handover FSM state register; the state doubles as DP_ACTIVE.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= DP_IDLE;
    else          state <= state_next;
  end

  // Next state follows the incoming transfer only when a phase completes.
  always_comb begin
    state_next   = state;
    DP_ACTIVE    = (state == DP_BUSY);
    handover_err = 1'b0;
    if (HREADY) begin
      state_next = sel_active ? DP_BUSY : DP_IDLE;
    end else if ((state == DP_BUSY) && (HMASTER != hmaster_prev)) begin
      handover_err = 1'b1;
    end
  end

  // Data-phase owner and direction advance only on completed cycles.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HMASTER_DP <= '0;
      WRITE_DP   <= 1'b0;
    end else if (HREADY) begin
      HMASTER_DP <= HMASTER;
      WRITE_DP   <= sel_write;
    end
  end

  // Track last cycle's HMASTER and latch a handover error until reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hmaster_prev <= '0;
      PROTO_ERR    <= 1'b0;
    end else begin
      hmaster_prev <= HMASTER;
      if (handover_err) PROTO_ERR <= 1'b1;
    end
  end

`ifdef AHB_MASTER_MUX_STATS_EN
  // Count completed data phases, saturating at all-ones.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      STAT_XFER_CNT <= '0;
    end else if (HREADY && DP_ACTIVE && (STAT_XFER_CNT != 32'hFFFF_FFFF)) begin
      STAT_XFER_CNT <= STAT_XFER_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/ahb_master_mux.sv
// AHB master multiplexer placed after the arbiter: steers the granted master
// onto the shared address/control bus and the data-phase owner onto HWDATA.
// Optional feature macro: AHB_MASTER_MUX_STATS_EN (adds STAT_XFER_CNT port).
module ahb_master_mux
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
)
(
  input  logic             HCLK,
  input  logic             HRESETn,
`ifdef AHB_MASTER_MUX_STATS_EN
  output logic [31:0]      STAT_XFER_CNT,
`endif
  ahb_master_mux_if.master bus
);

  logic sel_valid;
  logic sel_active;
  logic write_dp;

  // Address-phase mux; an out-of-range HMASTER presents an IDLE, all-zero bus.
  always_comb begin
    sel_valid  = (int'(bus.HMASTER) < NUM_MASTERS);
    bus.HADDR  = '0;
    bus.HTRANS = IDLE;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = '0;
    bus.HBURST = '0;
    if (sel_valid) begin
      bus.HADDR  = bus.HADDRx[int'(bus.HMASTER)*ADDR_W +: ADDR_W];
      bus.HTRANS = bus.HTRANSx[int'(bus.HMASTER)*2 +: 2];
      bus.HWRITE = bus.HWRITEx[int'(bus.HMASTER)];
      bus.HSIZE  = bus.HSIZEx[int'(bus.HMASTER)*3 +: 3];
      bus.HBURST = bus.HBURSTx[int'(bus.HMASTER)*3 +: 3];
    end
  end

  assign sel_active = sel_valid && is_active_trans(bus.HTRANS);

  // Write-data mux; only an active write data phase drives nonzero HWDATA.
  always_comb begin
    bus.HWDATA = '0;
    if (bus.DP_ACTIVE && write_dp && (int'(bus.HMASTER_DP) < NUM_MASTERS)) begin
      bus.HWDATA = bus.HWDATAx[int'(bus.HMASTER_DP)*DATA_W +: DATA_W];
    end
  end

  ahb_master_dp_tracker u_dp_tracker (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HMASTER       (bus.HMASTER),
    .HREADY        (bus.HREADY),
    .sel_active    (sel_active),
    .sel_write     (bus.HWRITE),
`ifdef AHB_MASTER_MUX_STATS_EN
    .STAT_XFER_CNT (STAT_XFER_CNT),
`endif
    .HMASTER_DP    (bus.HMASTER_DP),
    .DP_ACTIVE     (bus.DP_ACTIVE),
    .WRITE_DP      (write_dp),
    .PROTO_ERR     (bus.PROTO_ERR)
  );

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench for ahb_master_mux: a 16-master instance driven from a
// vector table, plus a 4-master instance for out-of-range HMASTER values.
// Optional feature macro: AHB_MASTER_MUX_STATS_EN (counter checks).
module tb_ahb_master_mux;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   checks = 0;
  int   passes = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_mux_if #(.NUM_MASTERS(16), .ADDR_W(32), .DATA_W(32)) bus16 ();
  ahb_master_mux_if #(.NUM_MASTERS(4),  .ADDR_W(32), .DATA_W(32)) bus4 ();

`ifdef AHB_MASTER_MUX_STATS_EN
  logic [31:0] stat16;
  logic [31:0] stat4;
`endif

  ahb_master_mux #(.NUM_MASTERS(16), .ADDR_W(32), .DATA_W(32)) dut16 (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
`ifdef AHB_MASTER_MUX_STATS_EN
    .STAT_XFER_CNT (stat16),
`endif
    .bus           (bus16)
  );

  ahb_master_mux #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
`ifdef AHB_MASTER_MUX_STATS_EN
    .STAT_XFER_CNT (stat4),
`endif
    .bus           (bus4)
  );

  typedef struct {
    logic [3:0]  mst;
    logic        rdy;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_mdp;
    logic        exp_dpa;
    logic [31:0] exp_wdata;
    logic        exp_perr;
  } vec_t;

  vec_t vecs [15];

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic setMaster16(input int m, input logic [1:0] t, input logic w,
                             input logic [2:0] b, input logic [31:0] a,
                             input logic [31:0] d);
    bus16.HADDRx[m*32 +: 32]  = a;
    bus16.HTRANSx[m*2 +: 2]   = t;
    bus16.HWRITEx[m]          = w;
    bus16.HBURSTx[m*3 +: 3]   = b;
    bus16.HWDATAx[m*32 +: 32] = d;
  endtask

  task automatic setMaster4(input int m, input logic [1:0] t, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    bus4.HADDRx[m*32 +: 32]  = a;
    bus4.HTRANSx[m*2 +: 2]   = t;
    bus4.HWRITEx[m]          = w;
    bus4.HWDATAx[m*32 +: 32] = d;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus16.HMASTER = v.mst;
    bus16.HREADY  = v.rdy;
    setMaster16(int'(v.mst), v.trans, v.wr, v.burst, v.addr, v.wdata);
    #2;
  endtask

  initial begin
    // Table: inputs for this cycle, then registered outputs expected before its edge.
    vecs[0]  = '{4'd3, 1'b1, 2'b10, 1'b1, 3'b000, 32'h1000_0040, 32'hDEAD_BEEF, 4'd0, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{4'd5, 1'b1, 2'b10, 1'b0, 3'b011, 32'h2000_0000, 32'h5555_0000, 4'd3, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{4'd5, 1'b1, 2'b11, 1'b0, 3'b011, 32'h2000_0004, 32'h5555_0001, 4'd5, 1'b1, 32'h0,         1'b0};
    vecs[3]  = '{4'd5, 1'b0, 2'b11, 1'b0, 3'b011, 32'h2000_0008, 32'h5555_0002, 4'd5, 1'b1, 32'h0,         1'b0};
    vecs[4]  = '{4'd5, 1'b0, 2'b11, 1'b0, 3'b011, 32'h2000_0008, 32'h5555_0002, 4'd5, 1'b1, 32'h0,         1'b0};
    vecs[5]  = '{4'd5, 1'b1, 2'b11, 1'b0, 3'b011, 32'h2000_0008, 32'h5555_0002, 4'd5, 1'b1, 32'h0,         1'b0};
    vecs[6]  = '{4'd5, 1'b1, 2'b11, 1'b0, 3'b011, 32'h2000_000C, 32'h5555_0003, 4'd5, 1'b1, 32'h0,         1'b0};
    vecs[7]  = '{4'd4, 1'b1, 2'b01, 1'b1, 3'b001, 32'h4000_0000, 32'h4444_4444, 4'd5, 1'b1, 32'h0,         1'b0};
    vecs[8]  = '{4'd4, 1'b1, 2'b00, 1'b0, 3'b000, 32'h4000_0004, 32'h4444_4444, 4'd4, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{4'd2, 1'b1, 2'b10, 1'b1, 3'b000, 32'h3000_0000, 32'h2222_2222, 4'd4, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{4'd2, 1'b0, 2'b10, 1'b1, 3'b000, 32'h3000_0010, 32'h2222_2222, 4'd2, 1'b1, 32'h2222_2222, 1'b0};
    vecs[11] = '{4'd7, 1'b0, 2'b10, 1'b0, 3'b000, 32'h7000_0000, 32'h7777_7777, 4'd2, 1'b1, 32'h2222_2222, 1'b0};
    vecs[12] = '{4'd7, 1'b1, 2'b10, 1'b0, 3'b000, 32'h7000_0000, 32'h7777_7777, 4'd2, 1'b1, 32'h2222_2222, 1'b1};
    vecs[13] = '{4'd7, 1'b1, 2'b00, 1'b0, 3'b000, 32'h7000_0004, 32'h7777_7777, 4'd7, 1'b1, 32'h0,         1'b1};
    vecs[14] = '{4'd0, 1'b1, 2'b00, 1'b0, 3'b000, 32'hA000_0000, 32'hD000_0000, 4'd7, 1'b0, 32'h0,         1'b1};

    HRESETn       = 1'b0;
    bus16.HMASTER = 4'd0;
    bus16.HREADY  = 1'b1;
    bus16.HSIZEx  = {16{3'b010}};
    for (int i = 0; i < 16; i++)
      setMaster16(i, 2'b00, 1'b0, 3'b000, 32'hA000_0000 + i*256, 32'hD000_0000 + i);
    bus4.HMASTER = 4'd0;
    bus4.HREADY  = 1'b1;
    bus4.HSIZEx  = '0;
    bus4.HBURSTx = '0;
    for (int i = 0; i < 4; i++)
      setMaster4(i, 2'b00, 1'b0, 32'hB000_0000 + i*256, 32'hB0B0_0000 + i);

    step();
    step();
    checkOutput("reset hmaster_dp", 32'(bus16.HMASTER_DP), 32'd0);
    checkOutput("reset dp_active",  32'(bus16.DP_ACTIVE),  32'd0);
    checkOutput("reset proto_err",  32'(bus16.PROTO_ERR),  32'd0);
    checkOutput("reset hwdata",     bus16.HWDATA,          32'd0);
    HRESETn = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d haddr", i),      bus16.HADDR,              vecs[i].addr);
      checkOutput($sformatf("v%0d htrans", i),     32'(bus16.HTRANS),        32'(vecs[i].trans));
      checkOutput($sformatf("v%0d hwrite", i),     32'(bus16.HWRITE),        32'(vecs[i].wr));
      checkOutput($sformatf("v%0d hburst", i),     32'(bus16.HBURST),        32'(vecs[i].burst));
      checkOutput($sformatf("v%0d hmaster_dp", i), 32'(bus16.HMASTER_DP),    32'(vecs[i].exp_mdp));
      checkOutput($sformatf("v%0d dp_active", i),  32'(bus16.DP_ACTIVE),     32'(vecs[i].exp_dpa));
      checkOutput($sformatf("v%0d hwdata", i),     bus16.HWDATA,             vecs[i].exp_wdata);
      checkOutput($sformatf("v%0d proto_err", i),  32'(bus16.PROTO_ERR),     32'(vecs[i].exp_perr));
      step();
    end

    // Sticky error clears only on reset.
    HRESETn = 1'b0;
    step();
    checkOutput("err reset proto_err", 32'(bus16.PROTO_ERR), 32'd0);
    checkOutput("err reset dp_active", 32'(bus16.DP_ACTIVE), 32'd0);
    HRESETn = 1'b1;

    // Reset during a wait-stated write aborts the data phase.
    bus16.HMASTER = 4'd2;
    bus16.HREADY  = 1'b1;
    setMaster16(2, 2'b10, 1'b1, 3'b000, 32'h3000_0020, 32'h2BAD_2BAD);
    step();
    checkOutput("abort pre dp_active", 32'(bus16.DP_ACTIVE), 32'd1);
    checkOutput("abort pre hwdata",    bus16.HWDATA,         32'h2BAD_2BAD);
    bus16.HREADY = 1'b0;
    HRESETn      = 1'b0;
    step();
    checkOutput("abort dp_active",  32'(bus16.DP_ACTIVE),  32'd0);
    checkOutput("abort hmaster_dp", 32'(bus16.HMASTER_DP), 32'd0);
    checkOutput("abort hwdata",     bus16.HWDATA,          32'd0);
    checkOutput("abort haddr comb", bus16.HADDR,           32'h3000_0020);
    HRESETn       = 1'b1;
    bus16.HREADY  = 1'b1;
    bus16.HMASTER = 4'd0;
    step();

    // Four-master instance: valid master first, then an out-of-range index.
    bus4.HMASTER = 4'd1;
    setMaster4(1, 2'b10, 1'b1, 32'hB100_0004, 32'hB1B1_B1B1);
    #2;
    checkOutput("m4 valid haddr", bus4.HADDR, 32'hB100_0004);
    step();
    checkOutput("m4 valid dp_active",  32'(bus4.DP_ACTIVE),  32'd1);
    checkOutput("m4 valid hmaster_dp", 32'(bus4.HMASTER_DP), 32'd1);
    checkOutput("m4 valid hwdata",     bus4.HWDATA,          32'hB1B1_B1B1);
    bus4.HMASTER = 4'd9;
    #2;
    checkOutput("m4 oor htrans", 32'(bus4.HTRANS), 32'd0);
    checkOutput("m4 oor haddr",  bus4.HADDR,       32'd0);
    checkOutput("m4 oor hwrite", 32'(bus4.HWRITE), 32'd0);
    step();
    checkOutput("m4 oor dp_active",  32'(bus4.DP_ACTIVE),  32'd0);
    checkOutput("m4 oor hmaster_dp", 32'(bus4.HMASTER_DP), 32'd9);
    checkOutput("m4 oor hwdata",     bus4.HWDATA,          32'd0);
    bus4.HMASTER = 4'd0;

`ifdef AHB_MASTER_MUX_STATS_EN
    // Ten completed transfers followed by idle cycles, then a reset.
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    bus16.HMASTER = 4'd1;
    bus16.HREADY  = 1'b1;
    setMaster16(1, 2'b10, 1'b0, 3'b000, 32'h1100_0000, 32'h1111_0000);
    for (int i = 0; i < 10; i++) step();
    setMaster16(1, 2'b00, 1'b0, 3'b000, 32'h1100_0000, 32'h1111_0000);
    for (int i = 0; i < 3; i++) step();
    checkOutput("stat count", stat16, 32'd10);
    setMaster16(1, 2'b10, 1'b0, 3'b000, 32'h1100_0000, 32'h1111_0000);
    step();
    step();
    HRESETn = 1'b0;
    step();
    checkOutput("stat reset", stat16, 32'd0);
    HRESETn = 1'b1;
`endif

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
